// File: rtl/dmd_pkg.sv
// Shared constants and types for the motion-detector frame store.
// Widths match the detector's memory master port; MEM_WORDS_DEFAULT covers one 640x480 frame.
package dmd_pkg;

  localparam int STREAM_WIDTH      = 8;
  localparam int DATA_WIDTH        = 4 * STREAM_WIDTH;
  localparam int ADDR_WIDTH        = 32;
  localparam int MEM_WORDS_DEFAULT = 76800;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACCESS,
    R_VALID
  } rd_state_t;

endpackage

// File: rtl/dmd_frame_mem_if.sv
// AW/W/AR/R bundle between the detector's memory master port and the frame store.
// There is no B channel: the detector never waits for write completion.
interface dmd_frame_mem_if;
  import dmd_pkg::*;

  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;

  modport master (
    output m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata,
    output m_axi_arvalid, m_axi_araddr, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_arready, m_axi_rvalid, m_axi_rdata
  );

  modport slave (
    input  m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata,
    input  m_axi_arvalid, m_axi_araddr, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_arready, m_axi_rvalid, m_axi_rdata
  );

endinterface

// File: rtl/dmd_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on a same-word collision.
// Written so it maps onto block RAM.
module dmd_sdp_ram #(
  parameter  int DEPTH = 76800,
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its output register have no reset; a reset would stop block-RAM inference,
  // and the read register only ever reaches the port through the top's R_VALID gating.
  // Non-blocking updates make the read sample the pre-write word, which is the read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata      <= mem[raddr];
  end

endmodule

// File: rtl/dmd_frame_mem.sv
// Background-frame store behind the detector's memory master port: one-entry AW/W holders,
// a three-state read FSM over a registered-read RAM, and a sticky out-of-range flag.
module dmd_frame_mem
  import dmd_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  dmd_frame_mem_if.slave bus,
  output logic          oob_err
);

  localparam int                IDX_W     = ADDR_WIDTH - 2;
  localparam int                RAM_IDX_W = $clog2(MEM_WORDS);
  localparam logic [IDX_W-1:0]  IDX_LIMIT = IDX_W'(MEM_WORDS);

  logic                  ready_en;
  logic                  aw_full, w_full;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  awready, wready, arready, rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  aw_fire, w_fire, ar_fire, r_fire;
  logic                  commit, wr_oob, ram_we, ram_re;
  rd_state_t             rd_state, rd_state_nxt;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_oob;
  logic [DATA_WIDTH-1:0] ram_q;

  // Byte-lane bits carry no information: every access is a full word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.m_axi_awaddr[1:0], bus.m_axi_araddr[1:0]};

  // Readys stay low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign awready = ready_en & ~aw_full;
  assign wready  = ready_en & ~w_full;
  assign aw_fire = bus.m_axi_awvalid & awready;
  assign w_fire  = bus.m_axi_wvalid  & wready;
  assign ar_fire = bus.m_axi_arvalid & arready;
  assign r_fire  = rvalid & bus.m_axi_rready;

  assign commit  = aw_full & w_full;
  assign wr_oob  = aw_idx >= IDX_LIMIT;
  assign ram_we  = commit & ~wr_oob;

  // Holders fill independently; the commit edge empties both, so neither channel can refill that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
    end else if (aw_fire) begin
      aw_full <= 1'b1;
      aw_idx  <= bus.m_axi_awaddr[ADDR_WIDTH-1:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_full <= 1'b0;
      w_data <= '0;
    end else if (commit) begin
      w_full <= 1'b0;
    end else if (w_fire) begin
      w_full <= 1'b1;
      w_data <= bus.m_axi_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_state <= R_IDLE;
    else      rd_state <= rd_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx <= '0;
      rd_oob <= 1'b0;
    end else if (ar_fire) begin
      rd_idx <= bus.m_axi_araddr[ADDR_WIDTH-1:2];
      rd_oob <= bus.m_axi_araddr[ADDR_WIDTH-1:2] >= IDX_LIMIT;
    end
  end

  // NOTE: every output of this block gets a default before the case so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    rd_state_nxt = rd_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    ram_re       = 1'b0;
    rdata        = '0;
    unique case (rd_state)
      R_IDLE: begin
        arready = ready_en;
        if (ar_fire) rd_state_nxt = R_ACCESS;
      end
      R_ACCESS: begin
        ram_re       = ~rd_oob;
        rd_state_nxt = R_VALID;
      end
      R_VALID: begin
        rvalid = 1'b1;
        rdata  = rd_oob ? '0 : ram_q;
        if (r_fire) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      oob_err <= 1'b0;
    else if ((commit && wr_oob) || (rd_state == R_ACCESS && rd_oob))
      oob_err <= 1'b1;
  end

  assign bus.m_axi_awready = awready;
  assign bus.m_axi_wready  = wready;
  assign bus.m_axi_arready = arready;
  assign bus.m_axi_rvalid  = rvalid;
  assign bus.m_axi_rdata   = rdata;

  dmd_sdp_ram #(
    .DEPTH (MEM_WORDS),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (aw_idx[RAM_IDX_W-1:0]),
    .wdata (w_data),
    .re    (ram_re),
    .raddr (rd_idx[RAM_IDX_W-1:0]),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_dmd_frame_mem.sv
// Directed bench for dmd_frame_mem: stimulus pushes expected read data into a scoreboard queue,
// a negedge monitor pops and compares on every R handshake.
module tb_dmd_frame_mem;
  import dmd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic oob_err;

  always #5 clk = ~clk;

  dmd_frame_mem_if bus ();

  dmd_frame_mem #(.MEM_WORDS(MEM_WORDS_DEFAULT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .oob_err (oob_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];

  localparam logic [31:0] OOB_ADDR  = 32'(MEM_WORDS_DEFAULT * 4);
  localparam logic [31:0] LAST_ADDR = 32'(MEM_WORDS_DEFAULT * 4 - 4);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_aw(input logic [31:0] a);
    logic hs;
    int   n;
    hs = 1'b0;
    n  = 0;
    bus.m_axi_awaddr  = a;
    bus.m_axi_awvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.m_axi_awready;
      tick();
      n++;
    end
    bus.m_axi_awvalid = 1'b0;
    check("aw_accept", 32'(hs), 32'd1);
  endtask

  task automatic write_w(input logic [31:0] d);
    logic hs;
    int   n;
    hs = 1'b0;
    n  = 0;
    bus.m_axi_wdata  = d;
    bus.m_axi_wvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.m_axi_wready;
      tick();
      n++;
    end
    bus.m_axi_wvalid = 1'b0;
    check("w_accept", 32'(hs), 32'd1);
  endtask

  // Returns in the cycle after the AR handshake edge (the R_ACCESS cycle).
  task automatic ar_issue(input logic [31:0] a, input logic [31:0] exp, input bit push);
    logic hs;
    int   n;
    hs = 1'b0;
    n  = 0;
    if (push) sb.push_back(exp);
    bus.m_axi_araddr  = a;
    bus.m_axi_arvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.m_axi_arready;
      tick();
      n++;
    end
    bus.m_axi_arvalid = 1'b0;
    check("ar_accept", 32'(hs), 32'd1);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("rsp_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    fork
      write_aw(a);
      write_w(d);
    join
    tick();
  endtask

  always @(negedge clk) begin
    if (rst && bus.m_axi_rvalid && bus.m_axi_rready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL r_unexpected: got 0x%08h expected no response", bus.m_axi_rdata);
      end else begin
        check("rdata", bus.m_axi_rdata, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_awaddr  = '0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_wdata   = '0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_araddr  = '0;
    bus.m_axi_rready  = 1'b1;

    // Reset and release timing of the readys.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("awready_in_rst", 32'(bus.m_axi_awready), 32'd0);
    check("wready_in_rst",  32'(bus.m_axi_wready),  32'd0);
    check("arready_in_rst", 32'(bus.m_axi_arready), 32'd0);
    check("rvalid_in_rst",  32'(bus.m_axi_rvalid),  32'd0);
    check("rdata_in_rst",   bus.m_axi_rdata,        32'd0);
    check("oob_in_rst",     32'(oob_err),           32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("arready_release", 32'(bus.m_axi_arready), 32'd0);
    check("awready_release", 32'(bus.m_axi_awready), 32'd0);
    tick();
    check("awready_up", 32'(bus.m_axi_awready), 32'd1);
    check("wready_up",  32'(bus.m_axi_wready),  32'd1);
    check("arready_up", 32'(bus.m_axi_arready), 32'd1);

    // Same-cycle AW/W, then read with latency check.
    fork
      write_aw(32'h10);
      write_w(32'hDEADBEEF);
    join
    ar_issue(32'h10, 32'hDEADBEEF, 1'b1);
    check("rvalid_lat_t1", 32'(bus.m_axi_rvalid), 32'd0);
    tick();
    check("rvalid_lat_t2", 32'(bus.m_axi_rvalid), 32'd1);
    wait_rsp();

    // W three cycles ahead of AW, and the reverse order.
    write_w(32'h11223344);
    repeat (3) begin
      check("wready_held", 32'(bus.m_axi_wready),  32'd0);
      check("awready_free", 32'(bus.m_axi_awready), 32'd1);
      tick();
    end
    write_aw(32'h20);
    tick();
    check("wready_after_commit", 32'(bus.m_axi_wready), 32'd1);
    write_aw(32'h24);
    repeat (3) tick();
    write_w(32'h55667788);
    tick();
    ar_issue(32'h20, 32'h11223344, 1'b1);
    wait_rsp();
    ar_issue(32'h24, 32'h55667788, 1'b1);
    wait_rsp();

    // Back-to-back writes: the second beat on each channel waits for the first commit.
    fork
      begin write_aw(32'h30); write_aw(32'h34); end
      begin write_w(32'hCAFE0001); write_w(32'hCAFE0002); end
    join
    tick();
    ar_issue(32'h30, 32'hCAFE0001, 1'b1);
    wait_rsp();
    ar_issue(32'h34, 32'hCAFE0002, 1'b1);
    wait_rsp();

    // R stall: rvalid/rdata hold, no new AR until after R fire.
    bus.m_axi_rready = 1'b0;
    ar_issue(32'h10, 32'hDEADBEEF, 1'b1);
    tick();
    bus.m_axi_araddr  = 32'h20;
    bus.m_axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid",  32'(bus.m_axi_rvalid),  32'd1);
      check("stall_rdata",   bus.m_axi_rdata,        32'hDEADBEEF);
      check("stall_arready", 32'(bus.m_axi_arready), 32'd0);
      tick();
    end
    sb.push_back(32'h11223344);
    bus.m_axi_rready = 1'b1;
    tick();
    check("arready_after_rfire", 32'(bus.m_axi_arready), 32'd1);
    tick();
    bus.m_axi_arvalid = 1'b0;
    wait_rsp();

    // Collision: commit of 0 and read access of 0x40 on the same edge return the old word.
    write_word(32'h40, 32'hAAAA5555);
    fork
      write_aw(32'h40);
      write_w(32'h00000000);
      ar_issue(32'h40, 32'hAAAA5555, 1'b1);
    join
    wait_rsp();
    ar_issue(32'h40, 32'h00000000, 1'b1);
    wait_rsp();

    // Last valid word, then out-of-range write and read.
    write_word(LAST_ADDR, 32'h0BADF00D);
    ar_issue(LAST_ADDR, 32'h0BADF00D, 1'b1);
    wait_rsp();
    check("oob_clear", 32'(oob_err), 32'd0);
    fork
      write_aw(OOB_ADDR);
      write_w(32'h12345678);
    join
    check("oob_before_commit", 32'(oob_err), 32'd0);
    tick();
    check("oob_after_write", 32'(oob_err), 32'd1);
    ar_issue(OOB_ADDR, 32'h00000000, 1'b1);
    wait_rsp();

    // Reset mid-read drops rvalid at once; RAM contents survive.
    bus.m_axi_rready = 1'b0;
    ar_issue(32'h10, 32'h0, 1'b0);
    tick();
    check("rvalid_pre_rst", 32'(bus.m_axi_rvalid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rvalid_mid_rst",  32'(bus.m_axi_rvalid),  32'd0);
    check("rdata_mid_rst",   bus.m_axi_rdata,        32'd0);
    check("arready_mid_rst", 32'(bus.m_axi_arready), 32'd0);
    check("oob_mid_rst",     32'(oob_err),           32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.m_axi_rready = 1'b1;
    tick();
    check("arready_post_rst", 32'(bus.m_axi_arready), 32'd1);
    ar_issue(32'h10, 32'hDEADBEEF, 1'b1);
    wait_rsp();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
